// File: rtl/ahb_rr_arbiter.sv
// Parametrised AHB bus arbiter: round-robin or fixed priority, burst-length-aware handover,
// locked transfers and SPLIT masking with hsplit resume.
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int MW              = 2,
    parameter int PRIORITY_MODE   = 0,
    parameter int DEFAULT_MASTER  = 0,
    parameter int MAX_UNDEF_BEATS = 16
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [NUM_MASTERS-1:0] hsplit,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic [1:0]             hresp,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock,
    output logic [1:0]             arb_state
);
    localparam int LMAX = (MAX_UNDEF_BEATS > 16) ? MAX_UNDEF_BEATS : 16;
    localparam int CW   = $clog2(LMAX + 1);
    localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    typedef enum logic [1:0] {
        IDLE_ARB = 2'd0,
        BURST    = 2'd1,
        LOCKED   = 2'd2,
        RESP2    = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt, blen;
    logic [NUM_MASTERS-1:0] mask, mask_nxt, eligible, grant_nxt;
    logic [MW-1:0]          ptr, grant_idx, winner;
    logic                   is_idle, is_nonseq, is_seq;
    logic                   last_beat, lock_hold, rearb_req, arb_ok, resp_first, found;
    int                     idx;

    assign arb_state = state;
    assign is_idle   = (htrans == 2'd0);
    assign is_nonseq = (htrans == 2'd2);
    assign is_seq    = (htrans == 2'd3);

    always_comb begin
        case (hburst)
            3'd0:       blen = CW'(1);
            3'd1:       blen = CW'(MAX_UNDEF_BEATS);
            3'd2, 3'd3: blen = CW'(4);
            3'd4, 3'd5: blen = CW'(8);
            default:    blen = CW'(16);
        endcase
    end

    assign last_beat  = (is_nonseq && blen == CW'(1)) || (is_seq && cnt == CW'(1));
    assign lock_hold  = hmastlock & hlock[hmaster];
    assign rearb_req  = (state == RESP2);
    // A SPLIT/RETRY re-arbitration must break a lock, so it bypasses lock_hold.
    assign arb_ok     = rearb_req | (~lock_hold & (is_idle | last_beat));
    assign resp_first = ~hready & (hresp == 2'd2 || hresp == 2'd3) & (state != RESP2);
    assign eligible   = hbusreq & ~mask;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant[i]) grant_idx = MW'(i);
        end
    end

    always_comb begin
        winner = MW'(DEFAULT_MASTER);
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (PRIORITY_MODE == 0) idx = (int'(ptr) + k) % NUM_MASTERS;
            else                    idx = k - 1;
            if (!found && eligible[idx]) begin
                winner = MW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        grant_nxt         = '0;
        grant_nxt[winner] = 1'b1;
    end

    always_comb begin
        mask_nxt = mask;
        if (resp_first && hresp == 2'd3) mask_nxt[hmaster] = 1'b1;
        mask_nxt = mask_nxt & ~hsplit;
    end

    always_comb begin
        cnt_nxt = cnt;
        if (state == RESP2)               cnt_nxt = '0;
        else if (is_nonseq)               cnt_nxt = blen - CW'(1);
        else if (is_seq && cnt != '0)     cnt_nxt = cnt - CW'(1);
    end

    always_comb begin
        state_nxt = state;
        if (resp_first) begin
            state_nxt = RESP2;
        end else if (hready) begin
            case (state)
                IDLE_ARB: if (is_nonseq) begin
                    if (hmastlock)       state_nxt = LOCKED;
                    else if (!last_beat) state_nxt = BURST;
                end
                BURST:    if (last_beat || is_idle) state_nxt = IDLE_ARB;
                LOCKED:   if (!hlock[hmaster] && arb_ok) state_nxt = IDLE_ARB;
                default:  state_nxt = IDLE_ARB;
            endcase
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) state <= IDLE_ARB;
        else        state <= state_nxt;
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hgrant    <= DEFAULT_GRANT;
            hmaster   <= MW'(DEFAULT_MASTER);
            hmastlock <= 1'b0;
            cnt       <= '0;
            mask      <= '0;
            ptr       <= MW'(DEFAULT_MASTER);
        end else begin
            mask <= mask_nxt;
            if (hready) begin
                hmaster   <= grant_idx;
                hmastlock <= hlock[grant_idx];
                cnt       <= cnt_nxt;
                if (arb_ok) begin
                    hgrant <= grant_nxt;
                    ptr    <= winner;
                end
            end
        end
    end
endmodule
